// File: rtl/cmos_cfg_pkg.sv
// Shared types and constants for the camera power-up / register configuration sequencer.
package cmos_cfg_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PWDN,
        S_RST,
        S_INIT,
        S_FETCH,
        S_LATCH,
        S_WRITE,
        S_RETRY,
        S_DELAY,
        S_DONE,
        S_ERROR
    } cfg_state_e;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } lut_entry_t;

    localparam logic [15:0] DELAY_ADDR_DEF = 16'hFFFF;
    localparam int          MS_W           = 16;

endpackage

// File: rtl/cmos_cfg_timer.sv
// Millisecond timer: a tick prescaler feeding a ms down-counter; both restart on load.
module cmos_cfg_timer
    import cmos_cfg_pkg::*;
#(
    parameter int TICKS_PER_MS = 50000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            count,
    input  logic [MS_W-1:0] load_ms,
    output logic            expired
);

    localparam int             PW         = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICKS_PER_MS - 1);

    logic [PW-1:0]   presc;
    logic [MS_W-1:0] ms_left;
    logic            presc_wrap;

    assign presc_wrap = (presc == PRESC_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc   <= '0;
            ms_left <= '0;
        end else if (load) begin
            presc   <= '0;
            ms_left <= load_ms;
        end else if (count && (ms_left != '0)) begin
            if (presc_wrap) begin
                presc   <= '0;
                ms_left <= ms_left - 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    // Flag expiry one cycle early so the owning state lasts exactly N*TICKS_PER_MS cycles.
    assign expired = (ms_left == '0) || ((ms_left == MS_W'(1)) && presc_wrap);

endmodule

// File: rtl/cmos_cfg_seq.sv
// DVP sensor power-up sequencer and LUT-driven SCCB register writer with per-entry retry.
module cmos_cfg_seq
    import cmos_cfg_pkg::*;
#(
    parameter int          LUT_SIZE     = 256,
    parameter int          TICKS_PER_MS = 50000,
    parameter int          PWDN_MS      = 5,
    parameter int          RST_MS       = 5,
    parameter int          INIT_MS      = 20,
    parameter int          MAX_RETRY    = 3,
    parameter logic [15:0] DELAY_ADDR   = DELAY_ADDR_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    output logic [$clog2(LUT_SIZE)-1:0] lut_index,
    input  logic [23:0]                 lut_data,
    output logic                        cmos_pwdn,
    output logic                        cmos_rst_n,
    output logic                        wr_req,
    output logic [15:0]                 wr_addr,
    output logic [7:0]                  wr_data,
    input  logic                        wr_done,
    input  logic                        wr_err,
    output logic                        cfg_busy,
    output logic                        cfg_done,
    output logic                        cfg_error,
    output logic [$clog2(LUT_SIZE)-1:0] err_index
);

    localparam int                IDX_W    = $clog2(LUT_SIZE);
    localparam int                RW       = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(LUT_SIZE - 1);

    cfg_state_e      state, state_n;
    lut_entry_t      ent;
    logic [RW-1:0]   retry;
    logic            tmr_load, tmr_count, tmr_exp;
    logic [MS_W-1:0] tmr_ms;
    logic            idx_clr, idx_inc, ent_load, retry_inc, err_cap;
    logic            at_last;

    assign ent     = lut_data;
    assign at_last = (lut_index == LAST_IDX);

    cmos_cfg_timer #(
        .TICKS_PER_MS (TICKS_PER_MS)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (tmr_load),
        .count   (tmr_count),
        .load_ms (tmr_ms),
        .expired (tmr_exp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        tmr_load  = 1'b0;
        tmr_ms    = '0;
        idx_clr   = 1'b0;
        idx_inc   = 1'b0;
        ent_load  = 1'b0;
        retry_inc = 1'b0;
        err_cap   = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_n  = S_PWDN;
                    idx_clr  = 1'b1;
                    tmr_load = 1'b1;
                    tmr_ms   = MS_W'(PWDN_MS);
                end
            end
            S_PWDN: begin
                if (tmr_exp) begin
                    state_n  = S_RST;
                    tmr_load = 1'b1;
                    tmr_ms   = MS_W'(RST_MS);
                end
            end
            S_RST: begin
                if (tmr_exp) begin
                    state_n  = S_INIT;
                    tmr_load = 1'b1;
                    tmr_ms   = MS_W'(INIT_MS);
                end
            end
            S_INIT: begin
                if (tmr_exp) state_n = S_FETCH;
            end
            S_FETCH: state_n = S_LATCH;
            S_LATCH: begin
                if (ent.addr == DELAY_ADDR) begin
                    state_n  = S_DELAY;
                    tmr_load = 1'b1;
                    tmr_ms   = MS_W'(ent.data);
                end else begin
                    state_n  = S_WRITE;
                    ent_load = 1'b1;
                end
            end
            S_WRITE: begin
                // An error pulse wins over a simultaneous done pulse.
                if (wr_err) begin
                    if (retry < RW'(MAX_RETRY)) begin
                        state_n   = S_RETRY;
                        retry_inc = 1'b1;
                    end else begin
                        state_n = S_ERROR;
                        err_cap = 1'b1;
                    end
                end else if (wr_done) begin
                    if (at_last) begin
                        state_n = S_DONE;
                    end else begin
                        state_n = S_FETCH;
                        idx_inc = 1'b1;
                    end
                end
            end
            S_RETRY: state_n = S_WRITE;
            S_DELAY: begin
                if (tmr_exp) begin
                    if (at_last) begin
                        state_n = S_DONE;
                    end else begin
                        state_n = S_FETCH;
                        idx_inc = 1'b1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lut_index <= '0;
            wr_addr   <= '0;
            wr_data   <= '0;
            retry     <= '0;
            err_index <= '0;
        end else begin
            if (idx_clr) begin
                lut_index <= '0;
            end else if (idx_inc) begin
                lut_index <= lut_index + 1'b1;
            end
            if (ent_load) begin
                wr_addr <= ent.addr;
                wr_data <= ent.data;
                retry   <= '0;
            end else if (retry_inc) begin
                retry <= retry + 1'b1;
            end
            if (err_cap) begin
                err_index <= lut_index;
            end
        end
    end

    assign tmr_count  = (state == S_PWDN) || (state == S_RST) || (state == S_INIT) || (state == S_DELAY);
    assign cmos_pwdn  = (state == S_IDLE) || (state == S_PWDN);
    assign cmos_rst_n = !((state == S_IDLE) || (state == S_PWDN) || (state == S_RST));
    assign wr_req     = (state == S_WRITE);
    assign cfg_busy   = !((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
    assign cfg_done   = (state == S_DONE);
    assign cfg_error  = (state == S_ERROR);

endmodule

// File: tb/tb_cmos_cfg_seq.sv
// Randomized bench for cmos_cfg_seq: SCCB responder, bus monitor and a transaction-level reference.
module tb_cmos_cfg_seq;

    localparam int LUT_SIZE  = 4;
    localparam int TPM       = 4;
    localparam int PWDN_MS   = 5;
    localparam int RST_MS    = 5;
    localparam int INIT_MS   = 20;
    localparam int MAX_RETRY = 3;
    localparam int IW        = $clog2(LUT_SIZE);
    localparam int BOUND     = 20000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          wr_done = 1'b0;
    logic          wr_err = 1'b0;
    logic [IW-1:0] lut_index, err_index;
    logic [23:0]   lut_data = '0;
    logic          cmos_pwdn, cmos_rst_n, wr_req, cfg_busy, cfg_done, cfg_error;
    logic [15:0]   wr_addr;
    logic [7:0]    wr_data;

    int n_checks = 0;
    int n_err    = 0;

    cmos_cfg_seq #(
        .LUT_SIZE     (LUT_SIZE),
        .TICKS_PER_MS (TPM),
        .PWDN_MS      (PWDN_MS),
        .RST_MS       (RST_MS),
        .INIT_MS      (INIT_MS),
        .MAX_RETRY    (MAX_RETRY),
        .DELAY_ADDR   (16'hFFFF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .lut_index  (lut_index),
        .lut_data   (lut_data),
        .cmos_pwdn  (cmos_pwdn),
        .cmos_rst_n (cmos_rst_n),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_done    (wr_done),
        .wr_err     (wr_err),
        .cfg_busy   (cfg_busy),
        .cfg_done   (cfg_done),
        .cfg_error  (cfg_error),
        .err_index  (err_index)
    );

    always #5 clk = ~clk;

    // External LUT: synchronous read, data one cycle after the index.
    logic [23:0] lut_mem [LUT_SIZE];
    always @(posedge clk) lut_data <= lut_mem[lut_index];

    // Responder script, written by the main process only.
    int err_plan  [LUT_SIZE];
    bit both_plan [LUT_SIZE];
    bit hang      [LUT_SIZE];
    int inject_req = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    initial begin : responder
        int attempts [LUT_SIZE];
        int inject_ack;
        int lat, idx;
        inject_ack = 0;
        foreach (attempts[i]) attempts[i] = 0;
        forever begin
            @(negedge clk);
            if (!cfg_busy) foreach (attempts[i]) attempts[i] = 0;
            if (inject_ack != inject_req) begin
                inject_ack = inject_req;
                wr_done = 1'b1;
                @(negedge clk);
                wr_done = 1'b0;
            end else if (rst_n && wr_req && !hang[lut_index]) begin
                idx = int'(lut_index);
                attempts[idx]++;
                lat = $urandom_range(1, 6);
                repeat (lat - 1) @(negedge clk);
                if (attempts[idx] <= err_plan[idx]) begin
                    wr_err  = 1'b1;
                    wr_done = both_plan[idx];
                end else begin
                    wr_done = 1'b1;
                end
                @(negedge clk);
                wr_err  = 1'b0;
                wr_done = 1'b0;
            end
        end
    end

    // Bus monitor: timestamps in negedge counts, cleared when a new sequence starts.
    int          cyc = 0;
    int          busy_rise = 0, pwdn_fall = -1, rst_rise = -1, unstable = 0;
    int          rise_q[$], fall_q[$], idx_q[$];
    logic [15:0] addr_q[$];
    logic [7:0]  data_q[$];

    initial begin : monitor
        logic prev_req, prev_busy, prev_pwdn, prev_rstn;
        prev_req = 1'b0; prev_busy = 1'b0; prev_pwdn = 1'b1; prev_rstn = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (cfg_busy && !prev_busy) begin
                busy_rise = cyc;
                pwdn_fall = -1;
                rst_rise  = -1;
                unstable  = 0;
                rise_q.delete(); fall_q.delete(); idx_q.delete();
                addr_q.delete(); data_q.delete();
            end
            if (prev_pwdn && !cmos_pwdn) pwdn_fall = cyc;
            if (!prev_rstn && cmos_rst_n) rst_rise = cyc;
            if (wr_req && !prev_req) begin
                rise_q.push_back(cyc);
                addr_q.push_back(wr_addr);
                data_q.push_back(wr_data);
                idx_q.push_back(int'(lut_index));
            end else if (wr_req && (addr_q.size() > 0) &&
                         ((wr_addr != addr_q[$]) || (wr_data != data_q[$]))) begin
                unstable++;
            end
            if (!wr_req && prev_req) fall_q.push_back(cyc);
            prev_req  = wr_req;
            prev_busy = cfg_busy;
            prev_pwdn = cmos_pwdn;
            prev_rstn = cmos_rst_n;
        end
    end

    task automatic do_start(input string tag);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_after_start"}, 32'(cfg_busy), 1);
        check({tag, "_idx_after_start"}, 32'(lut_index), 0);
        check({tag, "_flags_after_start"}, {29'd0, cmos_pwdn, cmos_rst_n, cfg_done | cfg_error}, 32'b100);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (cfg_busy && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (cfg_busy) check({tag, "_timeout"}, 1, 0);
    endtask

    // Reference: from the LUT and the responder script, derive the writes the bus should carry,
    // the idle cycles before each write, and the final status.
    task automatic run_and_check(input string tag, input bit poke_init);
        int          e_gap[$], e_idx[$];
        logic [15:0] e_addr[$];
        logic [7:0]  e_data[$];
        logic [15:0] a;
        int          d, acc, n, nreq_now, got_gap;
        bit          failed;
        int          fail_idx;
        acc = INIT_MS * TPM;
        failed = 1'b0;
        fail_idx = 0;
        for (int i = 0; i < LUT_SIZE && !failed; i++) begin
            a = lut_mem[i][23:8];
            d = int'(lut_mem[i][7:0]);
            if (a == 16'hFFFF) begin
                acc += 2 + ((d * TPM > 0) ? d * TPM : 1);
            end else begin
                acc += 2;
                n = (err_plan[i] > MAX_RETRY) ? MAX_RETRY + 1 : err_plan[i] + 1;
                for (int k = 0; k < n; k++) begin
                    e_gap.push_back((k == 0) ? acc : 1);
                    e_addr.push_back(a);
                    e_data.push_back(lut_mem[i][7:0]);
                    e_idx.push_back(i);
                end
                if (err_plan[i] > MAX_RETRY) begin
                    failed = 1'b1;
                    fail_idx = i;
                end
                acc = 0;
            end
        end

        do_start(tag);
        if (poke_init) begin
            n = 0;
            while (!cmos_rst_n && n < BOUND) begin
                @(negedge clk);
                n++;
            end
            repeat (5) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check({tag, "_start_in_init_ignored"}, {30'd0, cfg_busy, cmos_rst_n}, 32'b11);
        end
        wait_idle(tag);

        check({tag, "_pwdn_time"}, 32'(pwdn_fall - busy_rise), PWDN_MS * TPM);
        check({tag, "_rst_time"}, 32'(rst_rise - pwdn_fall), RST_MS * TPM);
        check({tag, "_nreq"}, 32'(rise_q.size()), 32'(e_addr.size()));
        for (int k = 0; k < e_addr.size() && k < rise_q.size(); k++) begin
            got_gap = (k == 0) ? rise_q[0] - rst_rise : rise_q[k] - fall_q[k - 1];
            check($sformatf("%s_addr%0d", tag, k), 32'(addr_q[k]), 32'(e_addr[k]));
            check($sformatf("%s_data%0d", tag, k), 32'(data_q[k]), 32'(e_data[k]));
            check($sformatf("%s_idx%0d", tag, k), 32'(idx_q[k]), 32'(e_idx[k]));
            check($sformatf("%s_gap%0d", tag, k), 32'(got_gap), 32'(e_gap[k]));
        end
        check({tag, "_stable"}, 32'(unstable), 0);
        check({tag, "_done"}, 32'(cfg_done), failed ? 0 : 1);
        check({tag, "_error"}, 32'(cfg_error), failed ? 1 : 0);
        check({tag, "_end_pins"}, {29'd0, wr_req, cmos_pwdn, cmos_rst_n}, 32'b001);
        if (failed) begin
            check({tag, "_err_index"}, 32'(err_index), 32'(fail_idx));
            nreq_now = rise_q.size();
            repeat (40) @(negedge clk);
            check({tag, "_no_more_req"}, 32'(rise_q.size()), 32'(nreq_now));
        end
    endtask

    task automatic clear_plan();
        for (int i = 0; i < LUT_SIZE; i++) begin
            err_plan[i]  = 0;
            both_plan[i] = 1'b0;
            hang[i]      = 1'b0;
        end
    endtask

    task automatic rand_lut(input int delay_pct);
        for (int i = 0; i < LUT_SIZE; i++) begin
            if ($urandom_range(0, 99) < delay_pct)
                lut_mem[i] = {16'hFFFF, 8'($urandom_range(0, 3))};
            else
                lut_mem[i] = {16'($urandom_range(0, 16'hFFFE)), 8'($urandom_range(0, 255))};
        end
    endtask

    initial begin : main
        int n;
        clear_plan();
        rand_lut(0);
        repeat (2) @(negedge clk);
        check("reset_pins", {27'd0, cmos_pwdn, cmos_rst_n, wr_req, cfg_busy, cfg_done | cfg_error}, 32'b10000);
        check("reset_regs", {wr_addr, wr_data, 2'd0, 6'(lut_index)}, 0);
        check("reset_err_index", 32'(err_index), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_without_start", 32'(cfg_busy), 0);

        // All writes acked.
        run_and_check("basic", 1'b0);

        // Delay entry between two writes.
        rand_lut(0);
        lut_mem[1] = {16'hFFFF, 8'd2};
        run_and_check("delay", 1'b0);

        // Two NACKs then success on entry 1.
        rand_lut(0);
        err_plan[1] = 2;
        run_and_check("retry", 1'b0);

        // Entry 2 never succeeds, then restart from ERROR.
        rand_lut(0);
        clear_plan();
        err_plan[2] = 9;
        run_and_check("exhaust", 1'b0);
        clear_plan();
        run_and_check("restart", 1'b0);

        // Start during INIT plus done+err together on entry 0.
        rand_lut(0);
        err_plan[0]  = 1;
        both_plan[0] = 1'b1;
        run_and_check("init_start", 1'b1);

        // Zero-length delay and a delay as the last entry.
        clear_plan();
        rand_lut(0);
        lut_mem[1] = {16'hFFFF, 8'd0};
        lut_mem[3] = {16'hFFFF, 8'd1};
        run_and_check("edge_delay", 1'b0);

        for (int r = 0; r < 5; r++) begin
            rand_lut(25);
            for (int i = 0; i < LUT_SIZE; i++) begin
                err_plan[i]  = ($urandom_range(0, 9) == 0) ? 4 : $urandom_range(0, 2);
                both_plan[i] = 1'($urandom_range(0, 1));
            end
            run_and_check($sformatf("rand%0d", r), 1'b0);
        end

        // Reset while entry 1 is being requested.
        clear_plan();
        rand_lut(0);
        hang[1] = 1'b1;
        do_start("abort");
        n = 0;
        while (!(wr_req && lut_index == 1) && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached_entry1", {30'd0, wr_req, lut_index == 1}, 32'b11);
        rst_n = 1'b0;
        #1;
        check("abort_pins", {28'd0, wr_req, cmos_pwdn, cmos_rst_n, cfg_busy}, 32'b0100);
        check("abort_idx", 32'(lut_index), 0);
        @(negedge clk);
        rst_n = 1'b1;
        inject_req++;
        repeat (4) @(negedge clk);
        check("abort_late_done_ignored", {29'd0, cfg_busy, wr_req, cfg_done}, 0);
        check("abort_still_pwdn", {30'd0, cmos_pwdn, cmos_rst_n}, 32'b10);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
